// File: rtl/regfile_bank.sv
// 32 x WIDTH architectural register file: two combinational read ports, one write port,
// hardwired-zero register, optional WB->ID write-through bypass and a saturating write counter.
module regfile_bank #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [4:0]               wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [4:0]               rd_addr_a,
    input  logic [4:0]               rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic [NREGS*WIDTH-1:0]   regs_out,
    output logic [15:0]              wr_count
);

    localparam logic [4:0]  ZADDR   = 5'(ZERO_REG);
    localparam bit          BYP     = (BYPASS != 0);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] wr_sel;
    logic             commit;

    // wr_en gates everything, so an X address while idle cannot reach any enable.
    assign commit = wr_en && (wr_addr != ZADDR);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_sel = '0;
        if (commit) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs_q[i] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] q;
            // NOTE: this is a flop array, not a RAM macro, so every entry takes the async reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (wr_sel[i]) begin
                    // NOTE: sequential state uses non-blocking assignments only.
                    q <= wr_data;
                end
            end
            assign regs_q[i] = q;
        end
        assign regs_out[i*WIDTH +: WIDTH] = regs_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
        end else if (commit && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Each port forwards independently; regs_out deliberately shows stored state only.
    always_comb begin
        rd_data_a = (rd_addr_a == ZADDR) ? '0 : regs_q[rd_addr_a];
        if (BYP && commit && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = (rd_addr_b == ZADDR) ? '0 : regs_q[rd_addr_b];
        if (BYP && commit && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based reference model.
module tb_regfile_bank;

    localparam int W = 64;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [4:0]    rd_addr_a;
    logic [4:0]    rd_addr_b;

    logic [W-1:0]   rda1, rdb1, rda0, rdb0;
    logic [N*W-1:0] regs1, regs0;
    logic [15:0]    cnt1, cnt0;

    logic [W-1:0] model [N];
    int           model_cnt;
    int           checks = 0;
    int           errors = 0;

    regfile_bank #(.WIDTH(W), .NREGS(N), .BYPASS(1), .ZERO_REG(31)) dut1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda1), .rd_data_b(rdb1),
        .regs_out(regs1), .wr_count(cnt1)
    );

    regfile_bank #(.WIDTH(W), .NREGS(N), .BYPASS(0), .ZERO_REG(31)) dut0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda0), .rd_data_b(rdb0),
        .regs_out(regs0), .wr_count(cnt0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read-port value from the architectural rules.
    function automatic logic [W-1:0] exp_rd(input bit bypass, input logic [4:0] ra);
        if (ra == 5'd31) return '0;
        if (bypass && wr_en && (wr_addr == ra)) return wr_data;
        return model[ra];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) model[i] = '0;
        model_cnt = 0;
    endfunction

    function automatic void model_commit();
        if (wr_en && wr_addr != 5'd31) begin
            model[wr_addr] = wr_data;
            if (model_cnt < 65535) model_cnt++;
        end
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        model_commit();
        wr_en = 1'b0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_b1"}, regs1[i*W +: W], model[i]);
            check({tag, "_b0"}, regs0[i*W +: W], model[i]);
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_a_b1"}, rda1, exp_rd(1'b1, rd_addr_a));
        check({tag, "_b_b1"}, rdb1, exp_rd(1'b1, rd_addr_b));
        check({tag, "_a_b0"}, rda0, exp_rd(1'b0, rd_addr_a));
        check({tag, "_b_b0"}, rdb0, exp_rd(1'b0, rd_addr_b));
    endtask

    task automatic check_count(input string tag);
        check({tag, "_b1"}, W'(cnt1), W'(model_cnt));
        check({tag, "_b0"}, W'(cnt0), W'(model_cnt));
    endtask

    initial begin
        logic [W-1:0] last;

        // Reset held while a write is presented: nothing may be committed.
        model_clear();
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD;
        rd_addr_a = 5'd3; rd_addr_b = 5'd31;
        wr_en = 1'b1;
        #1;
        repeat (3) tick();
        check_all_regs("rst_regs");
        check("rst_rd_b", rdb1, '0);
        check("rst_rd_a_nobyp", rda0, '0);
        check_count("rst_cnt");

        // Release between edges; the first edge writes regs[3].
        reset_n = 1'b1;
        tick();
        model_commit();
        wr_en = 1'b0;
        check("rel_reg3", regs1[3*W +: W], 64'hDEAD);
        check_count("rel_cnt");

        // Reset again so the fill starts from a zero count.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_clear();
        tick();
        check_all_regs("rst2_regs");

        // Fill and read back.
        for (int i = 0; i < N; i++) write_reg(5'(i), 64'h1000 + 64'(i));
        check_count("fill_cnt");
        for (int i = 0; i < N; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check_reads("sweep");
        end
        check("fill_rd31", rda1, '0);

        // XZR write is dropped and never forwarded.
        rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        #1;
        check_reads("xzr_pre");
        tick();
        model_commit();
        wr_en = 1'b0;
        #1;
        check_reads("xzr_post");
        check("xzr_slice", regs1[31*W +: W], '0);
        check_count("xzr_cnt");

        // Same-cycle read/write of one register: bypass vs pre-write value.
        write_reg(5'd5, 64'hAAAA);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h5555;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        check("byp_a_b1", rda1, 64'h5555);
        check("byp_b_b1", rdb1, 64'h5555);
        check("byp_a_b0", rda0, 64'hAAAA);
        check("byp_b_b0", rdb0, 64'hAAAA);
        check("byp_regs_pre", regs1[5*W +: W], 64'hAAAA);
        tick();
        model_commit();
        wr_en = 1'b0;
        check("byp_regs_post_b1", regs1[5*W +: W], 64'h5555);
        check("byp_regs_post_b0", regs0[5*W +: W], 64'h5555);

        // Idle cycle with an unknown write address.
        wr_en = 1'b0; wr_addr = 5'bx; wr_data = 'x;
        tick();
        check_all_regs("xaddr_regs");
        check_count("xaddr_cnt");

        // Random traffic, biased toward read/write address collisions.
        for (int k = 0; k < 300; k++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = {$urandom, $urandom};
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            #1;
            check_reads("rand");
            tick();
            model_commit();
            check_count("rand_cnt");
            check("rand_slice", regs1[int'(wr_addr)*W +: W], model[wr_addr]);
        end
        wr_en = 1'b0;
        check_all_regs("rand_end");

        // Async reset between edges, with a write to regs[9] pending.
        write_reg(5'd7, 64'h77);
        check("async_pre7", regs1[7*W +: W], 64'h77);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("async_reg7_b1", regs1[7*W +: W], '0);
        check("async_reg7_b0", regs0[7*W +: W], '0);
        tick();
        check("async_reg9", regs1[9*W +: W], '0);
        check_count("async_cnt");
        wr_en = 1'b0;
        reset_n = 1'b1;
        tick();
        check_all_regs("async_regs");

        // Counter saturation on repeated writes to regs[1].
        wr_en = 1'b1; wr_addr = 5'd1;
        last = '0;
        for (int k = 0; k < 65534; k++) begin
            last = {$urandom, $urandom};
            wr_data = last;
            tick();
            model_commit();
        end
        check("sat_fffe", W'(cnt1), 64'hFFFE);
        for (int k = 0; k < 6; k++) begin
            last = {$urandom, $urandom};
            wr_data = last;
            tick();
            model_commit();
            check("sat_ffff_b1", W'(cnt1), 64'hFFFF);
            check("sat_ffff_b0", W'(cnt0), 64'hFFFF);
        end
        wr_en = 1'b0;
        check("sat_reg1", regs1[1*W +: W], last);
        check_count("sat_model_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
